// File: rtl/dmem_dump_arbiter_if.sv
// Shared data-RAM bus between the MEM stage, the debug dump channel and the RAM itself.
// The arbiter is the slave side; the surrounding pipeline/debug/RAM environment is the master.
interface dmem_dump_arbiter_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_pipe_we;
    logic [NB_ADDR-1:0] i_pipe_addr;
    logic [NB_DATA-1:0] i_pipe_wdata;
    logic [NB_DATA-1:0] o_pipe_rdata;
    logic               o_pipe_stall;

    logic               i_dbg_req;
    logic [NB_ADDR-1:0] i_dbg_base;
    logic [NB_ADDR:0]   i_dbg_count;
    logic               i_dbg_ready;
    logic               o_dbg_valid;
    logic [NB_DATA-1:0] o_dbg_data;
    logic               o_dbg_busy;
    logic               o_dbg_done;

    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [NB_DATA-1:0] i_mem_rdata;

    modport slave (
        input  i_pipe_we, i_pipe_addr, i_pipe_wdata,
        output o_pipe_rdata, o_pipe_stall,
        input  i_dbg_req, i_dbg_base, i_dbg_count, i_dbg_ready,
        output o_dbg_valid, o_dbg_data, o_dbg_busy, o_dbg_done,
        output o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_pipe_we, i_pipe_addr, i_pipe_wdata,
        input  o_pipe_rdata, o_pipe_stall,
        output i_dbg_req, i_dbg_base, i_dbg_count, i_dbg_ready,
        input  o_dbg_valid, o_dbg_data, o_dbg_busy, o_dbg_done,
        input  o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/dmem_dump_arbiter.sv
// Shares the single-port data RAM between the MEM stage and the debug dump engine.
// A dump stalls the pipeline, lets the in-flight access drain, then streams RAM words out.
module dmem_dump_arbiter #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic                clk,
    input  logic                i_rst_n,
    dmem_dump_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [NB_ADDR:0] FULL_COUNT = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_ADDR:0] ONE_WORD   = (NB_ADDR+1)'(1);

    state_t             state_q;
    logic [NB_ADDR-1:0] ptr_q;
    logic [NB_ADDR:0]   remaining_q;
    logic [NB_DATA-1:0] data_q;
    logic               stall_q;
    logic               valid_q;
    logic               done_q;
    logic [NB_ADDR:0]   count_d;
    logic               pipe_owns_ram;

    // Counts beyond the RAM size would revisit words, so cap at one full pass.
    always_comb begin
        count_d = bus.i_dbg_count;
        if (bus.i_dbg_count > FULL_COUNT) begin
            count_d = FULL_COUNT;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            stall_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_dbg_req) begin
                        ptr_q       <= bus.i_dbg_base;
                        remaining_q <= count_d;
                        stall_q     <= 1'b1;
                        if (count_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: state_q <= READ;
                READ: begin
                    data_q  <= bus.i_mem_rdata;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (bus.i_dbg_ready) begin
                        valid_q     <= 1'b0;
                        ptr_q       <= ptr_q + 1'b1;
                        remaining_q <= remaining_q - ONE_WORD;
                        if (remaining_q == ONE_WORD) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // DRAIN still hands the port to the pipeline so a store already in MEM commits.
    assign pipe_owns_ram = (state_q == IDLE) || (state_q == DRAIN);

    always_comb begin
        if (pipe_owns_ram) begin
            bus.o_mem_we    = bus.i_pipe_we;
            bus.o_mem_addr  = bus.i_pipe_addr;
            bus.o_mem_wdata = bus.i_pipe_wdata;
        end else begin
            bus.o_mem_we    = 1'b0;
            bus.o_mem_addr  = ptr_q;
            bus.o_mem_wdata = '0;
        end
    end

    assign bus.o_pipe_rdata = bus.i_mem_rdata;
    assign bus.o_pipe_stall = stall_q;
    assign bus.o_dbg_busy   = stall_q;
    assign bus.o_dbg_valid  = valid_q;
    assign bus.o_dbg_data   = data_q;
    assign bus.o_dbg_done   = done_q;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Randomised bench for dmem_dump_arbiter with a timeline-based reference model and directed
// literal checks for the documented dump sequences.
module tb_dmem_dump_arbiter;

    logic clk;
    logic rst_n;

    dmem_dump_arbiter_if #(.NB_DATA(32), .NB_ADDR(8)) bus ();

    dmem_dump_arbiter #(.NB_DATA(32), .NB_ADDR(8)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: synchronous write, asynchronous read.
    logic [31:0] ram [256];
    initial for (int i = 0; i < 256; i++) ram[i] = (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
    always @(posedge clk) if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    assign bus.i_mem_rdata = ram[bus.o_mem_addr];

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: tracks a dump as a timeline of cycle numbers, not as states.
    logic [31:0] mref [256];
    initial for (int i = 0; i < 256; i++) mref[i] = (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;

    int       c = 0;
    logic     m_act = 1'b0;
    int       m_req_c = 0;
    int       m_cnt = 0;
    int       m_sent = 0;
    int       m_valid_at = 0;
    int       m_done_at = -1;
    logic [7:0] m_base = '0;

    always @(negedge clk) begin : model
        logic pass, e_valid, e_done;
        logic [7:0] wptr;
        c++;
        if (!rst_n) m_act = 1'b0;
        if (m_act && m_done_at >= 0 && c > m_done_at) m_act = 1'b0;
        pass    = !m_act || (m_cnt != 0 && c == m_req_c + 1);
        e_valid = m_act && m_done_at < 0 && c >= m_valid_at;
        e_done  = m_act && c == m_done_at;
        wptr    = m_base + 8'(m_sent);

        chk("stall", bus.o_pipe_stall, m_act);
        chk("busy", bus.o_dbg_busy, m_act);
        chk("valid", bus.o_dbg_valid, e_valid);
        chk("done", bus.o_dbg_done, e_done);
        chk("mem_we", bus.o_mem_we, pass ? bus.i_pipe_we : 1'b0);
        chk("mem_wdata", bus.o_mem_wdata, pass ? bus.i_pipe_wdata : 32'h0);
        chk("pipe_rdata", bus.o_pipe_rdata, bus.i_mem_rdata);
        if (pass) chk("mem_addr_pipe", bus.o_mem_addr, bus.i_pipe_addr);
        else if (e_valid || (m_done_at < 0 && c == m_valid_at - 1))
            chk("mem_addr_dump", bus.o_mem_addr, wptr);
        if (e_valid) chk("dbg_data", bus.o_dbg_data, mref[wptr]);

        if (pass && bus.i_pipe_we) mref[bus.i_pipe_addr] = bus.i_pipe_wdata;
        if (rst_n) begin
            if (!m_act && bus.i_dbg_req) begin
                m_act      = 1'b1;
                m_req_c    = c;
                m_base     = bus.i_dbg_base;
                m_cnt      = (int'(bus.i_dbg_count) > 256) ? 256 : int'(bus.i_dbg_count);
                m_sent     = 0;
                m_valid_at = c + 3;
                m_done_at  = (m_cnt == 0) ? c + 1 : -1;
            end else if (e_valid && bus.i_dbg_ready) begin
                m_sent++;
                if (m_sent == m_cnt) m_done_at = c + 1;
                else m_valid_at = c + 2;
            end
        end
    end

    // Directed dump driver; records what it sees k cycles after the request edge.
    logic        obs_v  [32];
    logic        obs_dn [32];
    logic        obs_st [32];
    logic        obs_we [32];
    logic [31:0] obs_d  [32];
    logic [7:0]  obs_a  [32];
    int          last_done_k;
    int          valid_n;

    task automatic dump(input logic [7:0] base, input logic [8:0] cnt, input int lo_from,
                        input int lo_to, input int ncyc, input logic hold_we);
        bus.i_dbg_req   = 1'b1;
        bus.i_dbg_base  = base;
        bus.i_dbg_count = cnt;
        bus.i_dbg_ready = 1'b1;
        bus.i_pipe_we   = hold_we;
        last_done_k     = -1;
        valid_n         = 0;
        @(posedge clk); #1;
        bus.i_dbg_req = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            bus.i_dbg_ready = !(k >= lo_from && k <= lo_to);
            @(negedge clk);
            if (k < 32) begin
                obs_v[k]  = bus.o_dbg_valid;
                obs_dn[k] = bus.o_dbg_done;
                obs_st[k] = bus.o_pipe_stall;
                obs_we[k] = bus.o_mem_we;
                obs_d[k]  = bus.o_dbg_data;
                obs_a[k]  = bus.o_mem_addr;
            end
            if (bus.o_dbg_done && last_done_k < 0) last_done_k = k;
            if (bus.o_dbg_valid) valid_n++;
            @(posedge clk); #1;
        end
        bus.i_pipe_we = 1'b0;
    endtask

    task automatic store(input logic [7:0] a, input logic [31:0] d);
        bus.i_pipe_we    = 1'b1;
        bus.i_pipe_addr  = a;
        bus.i_pipe_wdata = d;
        @(posedge clk); #1;
        bus.i_pipe_we = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.i_pipe_we    = 1'b1;
        bus.i_pipe_addr  = 8'h05;
        bus.i_pipe_wdata = 32'h1234_5678;
        bus.i_dbg_req    = 1'b0;
        bus.i_dbg_base   = '0;
        bus.i_dbg_count  = '0;
        bus.i_dbg_ready  = 1'b0;
        #2;
        chk("rst_stall", bus.o_pipe_stall, 1'b0);
        chk("rst_valid", bus.o_dbg_valid, 1'b0);
        chk("rst_done", bus.o_dbg_done, 1'b0);
        chk("rst_data", bus.o_dbg_data, 32'h0);
        chk("rst_mem_we", bus.o_mem_we, 1'b1);
        chk("rst_mem_addr", bus.o_mem_addr, 8'h05);
        bus.i_pipe_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        bus.i_pipe_we    = 1'b1;
        bus.i_pipe_addr  = 8'h10;
        bus.i_pipe_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_we", bus.o_mem_we, 1'b1);
        chk("st_addr", bus.o_mem_addr, 8'h10);
        chk("st_stall", bus.o_pipe_stall, 1'b0);
        @(posedge clk); #1;
        bus.i_pipe_we = 1'b0;

        for (int i = 0; i < 4; i++) store(8'h20 + 8'(i), 32'(i + 1));
        store(8'hFF, 32'h0000_00AA);
        store(8'h00, 32'h0000_00BB);

        // Four words, ready high.
        dump(8'h20, 9'd4, 0, -1, 12, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("d1_valid_k%0d", k), obs_v[k], (k == 3 || k == 5 || k == 7 || k == 9));
            chk($sformatf("d1_done_k%0d", k), obs_dn[k], (k == 10));
            chk($sformatf("d1_stall_k%0d", k), obs_st[k], (k <= 10));
            if (k == 3 || k == 5 || k == 7 || k == 9)
                chk($sformatf("d1_data_k%0d", k), obs_d[k], 32'((k - 1) / 2));
        end

        // Same dump, ready low for five cycles while word 2 is offered.
        dump(8'h20, 9'd4, 5, 9, 16, 1'b0);
        for (int k = 5; k <= 10; k++) begin
            chk($sformatf("d2_valid_k%0d", k), obs_v[k], 1'b1);
            chk($sformatf("d2_data_k%0d", k), obs_d[k], 32'd2);
            chk($sformatf("d2_addr_k%0d", k), obs_a[k], 8'h21);
        end
        chk("d2_data_k12", obs_d[12], 32'd3);
        chk("d2_data_k14", obs_d[14], 32'd4);
        chk("d2_done_at", 32'(last_done_k), 32'd15);
        chk("d2_valid_cycles", 32'(valid_n), 32'd9);
        chk("d2_stall_k16", obs_st[16], 1'b0);

        // Store held across request and DRAIN, still held in SEND.
        bus.i_pipe_addr  = 8'h30;
        bus.i_pipe_wdata = 32'h0000_0055;
        dump(8'h30, 9'd1, 0, -1, 6, 1'b1);
        chk("d3_drain_we", obs_we[1], 1'b1);
        chk("d3_read_we", obs_we[2], 1'b0);
        chk("d3_send_we", obs_we[3], 1'b0);
        chk("d3_data", obs_d[3], 32'h0000_0055);
        chk("d3_done_at", 32'(last_done_k), 32'd4);

        // Zero-length dump.
        dump(8'h40, 9'd0, 0, -1, 3, 1'b0);
        chk("d4_done_at", 32'(last_done_k), 32'd1);
        chk("d4_valid_cycles", 32'(valid_n), 32'd0);
        chk("d4_stall_k1", obs_st[1], 1'b1);
        chk("d4_stall_k2", obs_st[2], 1'b0);

        // Address wrap.
        dump(8'hFF, 9'd2, 0, -1, 7, 1'b0);
        chk("d5_data_k3", obs_d[3], 32'h0000_00AA);
        chk("d5_data_k5", obs_d[5], 32'h0000_00BB);
        chk("d5_done_at", 32'(last_done_k), 32'd6);

        // Oversized count clamps to one pass over the whole RAM.
        dump(8'h00, 9'h1FF, 0, -1, 516, 1'b0);
        chk("d6_done_at", 32'(last_done_k), 32'd514);
        chk("d6_valid_cycles", 32'(valid_n), 32'd256);

        // Reset in the middle of SEND.
        bus.i_dbg_req   = 1'b1;
        bus.i_dbg_base  = 8'h20;
        bus.i_dbg_count = 9'd4;
        bus.i_dbg_ready = 1'b0;
        @(posedge clk); #1;
        bus.i_dbg_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("r_valid_before", bus.o_dbg_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("r_valid", bus.o_dbg_valid, 1'b0);
        chk("r_stall", bus.o_pipe_stall, 1'b0);
        chk("r_busy", bus.o_dbg_busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dump(8'h20, 9'd1, 0, -1, 5, 1'b0);
        chk("r_new_data", obs_d[3], 32'd1);
        chk("r_new_done_at", 32'(last_done_k), 32'd4);

        // Random traffic, occasional dumps and resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bus.i_pipe_we    = ($urandom_range(0, 2) == 0);
            bus.i_pipe_addr  = 8'($urandom_range(0, 255));
            bus.i_pipe_wdata = $urandom();
            bus.i_dbg_req    = ($urandom_range(0, 15) == 0);
            bus.i_dbg_base   = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 99));
            if (r < 80) bus.i_dbg_count = 9'($urandom_range(0, 5));
            else if (r < 97) bus.i_dbg_count = 9'($urandom_range(6, 20));
            else bus.i_dbg_count = 9'($urandom_range(0, 511));
            bus.i_dbg_ready = ($urandom_range(0, 3) != 0);
            rst_n           = ($urandom_range(0, 499) != 0);
            @(posedge clk); #1;
        end
        rst_n         = 1'b1;
        bus.i_dbg_req = 1'b0;
        bus.i_pipe_we = 1'b0;
        bus.i_dbg_ready = 1'b1;
        repeat (1100) @(posedge clk);
        @(negedge clk);
        chk("final_idle", bus.o_pipe_stall, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_dump_arbiter.md
# dmem_dump_arbiter

Owns the single-port data RAM behind the MEM stage and shares it between the pipeline and the debug unit. In normal operation the pipeline's address, write-enable and store data pass straight through. On a debug dump request the block stalls the pipeline and lets the in-flight MEM-stage access finish. It then walks a range of RAM words and streams them to the debug unit over a valid/ready handshake. Sits between memory_access and the data RAM, next to the debug UART controller.

## Interface
- NB_DATA, 32, RAM word width
- NB_ADDR, 8, RAM word address width (2^NB_ADDR words)

- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pipe_we  in  1  pipeline store enable (MEM stage)
- i_pipe_addr  in  NB_ADDR  pipeline word address
- i_pipe_wdata  in  NB_DATA  pipeline store data (already width-masked)
- o_pipe_rdata  out  NB_DATA  read data to MEM stage (= i_mem_rdata)
- o_pipe_stall  out  1  freeze pipeline while debug owns RAM
- i_dbg_req  in  1  dump request, sampled only in IDLE
- i_dbg_base  in  NB_ADDR  first word address, latched with request
- i_dbg_count  in  NB_ADDR+1  words to dump; values > 2^NB_ADDR clamp to 2^NB_ADDR
- i_dbg_ready  in  1  debug unit accepts o_dbg_data
- o_dbg_valid  out  1  o_dbg_data valid
- o_dbg_data  out  NB_DATA  dumped word (registered)
- o_dbg_busy  out  1  dump in progress (state != IDLE)
- o_dbg_done  out  1  one-cycle pulse at end of dump
- o_mem_we, o_mem_addr (NB_ADDR), o_mem_wdata (NB_DATA)  out  RAM write port / shared address
- i_mem_rdata  in  NB_DATA  RAM asynchronous read data

## Operation
- States: IDLE, DRAIN, READ, SEND, DONE. State, ptr, remaining and o_dbg_data are registered.
- IDLE: o_mem_we/addr/wdata = pipeline inputs (combinational pass-through). o_pipe_stall = 0.
  - If i_dbg_req = 1: latch ptr = i_dbg_base and remaining = clamped i_dbg_count.
  - Go to DONE if the count is 0, else DRAIN.
- DRAIN (exactly 1 cycle): o_pipe_stall = 1. RAM still driven by the pipeline so an in-flight store commits. Then go to READ.
- READ: o_mem_we = 0, o_mem_addr = ptr, o_mem_wdata = 0. o_dbg_data <= i_mem_rdata. Then go to SEND.
- SEND: o_dbg_valid = 1, o_dbg_data held stable, o_mem_we = 0. On i_dbg_ready = 1:
  - ptr <= ptr + 1, wrapping mod 2^NB_ADDR.
  - remaining <= remaining - 1.
  - Go to DONE if remaining == 1, else READ.
  - Without ready, stay in SEND indefinitely.
- DONE (1 cycle): o_dbg_done = 1, o_mem_we = 0, o_pipe_stall = 1. Then go to IDLE.
- o_pipe_stall = 1 in every state except IDLE. o_dbg_busy is the same signal.
- Pipeline writes arriving in READ/SEND/DONE are blocked (o_mem_we = 0); the stalled pipeline must re-present them after release.
- i_dbg_req outside IDLE is ignored; no queuing.
- o_pipe_rdata = i_mem_rdata at all times; only meaningful in IDLE/DRAIN.

## Timing
- Reset (async): state = IDLE, ptr = 0, remaining = 0, o_dbg_data = 0.
  - During reset, o_dbg_valid, o_dbg_done and o_pipe_stall are 0, and the memory port follows the pipeline.
- Reset mid-dump: returns to IDLE immediately, stall drops asynchronously, no done pulse. The partial dump is abandoned.
- Latency for a request sampled at edge 0:
  - DRAIN in cycle 1, READ in cycle 2.
  - First o_dbg_valid in cycle 3.
- With ready held high, each word takes 2 cycles (READ+SEND).
  - N-word dump: done pulse in cycle 2N+2; stall released (IDLE) in cycle 2N+3.
- Zero count: DONE in cycle 1, IDLE in cycle 2. No DRAIN, no valid.
- Address wrap: base 0xFE with count 4 reads 0xFE, 0xFF, 0x00, 0x01.
- Count 2^NB_ADDR reads every word once; remaining is wide enough to hold it.

## Test plan
- Store 0xDEADBEEF to addr 0x10 in IDLE; must see o_mem_we = 1 and addr 0x10 the same cycle, o_pipe_stall = 0.
- Preload words 0x20..0x23 = 1..4; req base 0x20 count 4, ready high → valid in cycles 3, 5, 7, 9 with data 1, 2, 3, 4; done in cycle 10; stall low from cycle 11.
- Same dump with ready low for 5 cycles on word 2 → data stays 2 with valid high throughout, no address advance, no extra words.
- Pipeline store asserted in the request cycle and held into DRAIN → store commits in DRAIN. Store attempted in SEND → o_mem_we = 0.
- Count 0 → done pulse in cycle 1, never valid. Base 0xFF count 2 → words from 0xFF then 0x00.
- Assert i_rst_n = 0 during SEND → valid, stall and busy drop immediately. After release, IDLE, and a new request works normally.
